// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer
//
// Supervises an EHXPLLL lock and drives its dynamic phase-adjust pins. Runs on the PLL
// reference clock so it never depends on a PLL output.
//
// Lock supervision: pll_locked is synchronised (2 FF) to lock_s. lock_s must stay high for
// LOCK_FILTER cycles before rst_out releases. A drop of lock_s at any time after that
// re-asserts rst_out.
//
// Phase stepping: a request of N steps on one PLL output does the following:
//   1. Presents phasesel/phasedir for SETUP_CYC cycles.
//   2. Emits N active-low phasestep pulses. Each pulse is low for PULSE_CYC cycles and is
//      followed by GAP_CYC high cycles.
//   3. Emits one phaseloadreg low pulse of PULSE_CYC cycles.
//   4. Signals completion with a single-cycle done pulse.
//
// Ports
//   clock             in   reference clock (25 MHz)
//   reset             in   synchronous, active-high reset
//   pll_locked        in   PLL LOCK, asynchronous to clock
//   rst_out           out  active-high reset for PLL-clocked logic
//   ready             out  lock filtered and sequencer idle
//   req_valid         in   phase-step request valid
//   req_ready         out  request accepted when req_valid & req_ready (combinational)
//   req_sel           in   PLL output select (0=CLKOP..3=CLKOS3)
//   req_dir           in   0=delay, 1=advance
//   req_steps         in   number of steps, 0..255
//   done              out  one-cycle pulse: request finished or aborted
//   error             out  qualified by done; 1 = aborted by lock loss
//   pll_phasesel      out  to PHASESEL[1:0]
//   pll_phasedir      out  to PHASEDIR
//   pll_phasestep     out  to PHASESTEP, idles high
//   pll_phaseloadreg  out  to PHASELOADREG, idles high

module pll_phase_sequencer #(
  parameter int unsigned LOCK_FILTER = 1024,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       ready,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  output logic       done,
  output logic       error,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg
);

  // Terminal values of the shared 16-bit cycle counter, one per timed state.
  localparam logic [15:0] SettleLast = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] SetupLast  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PulseLast  = 16'(PULSE_CYC - 1);
  localparam logic [15:0] GapLast    = 16'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    StWaitLock,
    StSettle,
    StReady,
    StSetup,
    StStepLo,
    StStepGap,
    StLoad,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;

  logic        lock_meta_q;
  logic        lock_s_q;

  logic        rst_out_q, rst_out_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  phasesel_q, phasesel_d;
  logic        phasedir_q, phasedir_d;
  logic        phasestep_q, phasestep_d;
  logic        phaseloadreg_q, phaseloadreg_d;

  logic        accept;

  // Lock synchroniser: nothing downstream looks at pll_locked directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Lock loss takes priority: no request is accepted while lock_s is low.
  assign req_ready = (state_q == StReady) && lock_s_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    phasesel_d = phasesel_q;
    phasedir_d = phasedir_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s_q) begin
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == SettleLast) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StReady: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d = StWaitLock;
        end else if (accept) begin
          rem_d = req_steps;
          if (req_steps == 8'd0) begin
            // Zero-step request completes without touching the PLL pins.
            state_d = StFinish;
          end else begin
            phasesel_d = req_sel;
            phasedir_d = req_dir;
            state_d    = StSetup;
          end
        end
      end

      StSetup: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (cnt_q == SetupLast) begin
          state_d = StStepLo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStepLo: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (cnt_q == PulseLast) begin
          state_d = StStepGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStepGap: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (cnt_q == GapLast) begin
          cnt_d = '0;
          // rem_q >= 1 here; the guard keeps the counter from ever wrapping.
          if (rem_q != 8'd0) begin
            rem_d = rem_q - 8'd1;
          end
          if (rem_q <= 8'd1) begin
            state_d = StLoad;
          end else begin
            state_d = StStepLo;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StLoad: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
          rem_d   = '0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (cnt_q == PulseLast) begin
          state_d = StFinish;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StFinish: begin
        // The request has completed, so done reports success even if lock drops now.
        done_d = 1'b1;
        cnt_d  = '0;
        if (lock_s_q) begin
          state_d = StReady;
        end else begin
          state_d = StWaitLock;
        end
      end

      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
        rem_d   = '0;
      end
    endcase

    // Pins follow the next state so that lock loss releases them on the same edge.
    rst_out_d      = (state_d == StWaitLock) || (state_d == StSettle);
    ready_d        = (state_d == StReady);
    phasestep_d    = (state_d != StStepLo);
    phaseloadreg_d = (state_d != StLoad);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StWaitLock;
      cnt_q          <= '0;
      rem_q          <= '0;
      rst_out_q      <= 1'b1;
      ready_q        <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      phasesel_q     <= '0;
      phasedir_q     <= 1'b0;
      phasestep_q    <= 1'b1;
      phaseloadreg_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      rst_out_q      <= rst_out_d;
      ready_q        <= ready_d;
      done_q         <= done_d;
      error_q        <= error_d;
      phasesel_q     <= phasesel_d;
      phasedir_q     <= phasedir_d;
      phasestep_q    <= phasestep_d;
      phaseloadreg_q <= phaseloadreg_d;
    end
  end

  assign rst_out          = rst_out_q;
  assign ready            = ready_q;
  assign done             = done_q;
  assign error            = error_q;
  assign pll_phasesel     = phasesel_q;
  assign pll_phasedir     = phasedir_q;
  assign pll_phasestep    = phasestep_q;
  assign pll_phaseloadreg = phaseloadreg_q;

endmodule
